layer_regfile_mp: RTL and testbench

LAYER_REGFILE_MP -- requirements
Module: layer_regfile_mp

---
 rtl/layer_regfile_mp.sv | 164 ++++++++++++++++
 tb/tb_layer_regfile_mp.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_regfile_mp.sv
// Purpose : multi-port register file of {data, tag, valid} entries with clear sweep and dump stream.
// Latency : reads are combinational (optional write-through bypass); writes land on the next rising edge.
// Backpressure : the dump stream holds address/data/tag while dump_ready_i is low; the clear sweep cannot be stalled.
//
// Ports:
//   clk_i, reset                 clock, asynchronous active-low reset
//   rs/rt/op_addr_i -> *_data_o  three combinational read ports; op port also returns tag and valid
//   we_i, wd_addr/data/tag_i     write port (dropped while the clear sweep runs)
//   clr_i, dump_req_i            single-cycle pulses starting the clear sweep / dump stream
//   dump_*                       valid/ready dump stream, one entry per transfer, last on DEPTH-1
//   busy_o, vld_cnt_o            FSM not idle, number of valid entries
module layer_regfile_mp #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 32,
  parameter int BYPASS = 1,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic [ADDR_W-1:0] op_addr_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic [DATA_W-1:0] op_data_o,
  output logic [TAG_W-1:0]  op_tag_o,
  output logic              op_vld_o,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] wd_addr_i,
  input  logic [DATA_W-1:0] wd_data_i,
  input  logic [TAG_W-1:0]  wd_tag_i,
  input  logic              clr_i,
  input  logic              dump_req_i,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_addr_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic [TAG_W-1:0]  dump_tag_o,
  output logic              dump_last_o,
  output logic              busy_o,
  output logic [ADDR_W:0]   vld_cnt_o
);

  localparam bit              BYP      = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DUMP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W:0]   vld_cnt_q;

  logic wr_acc;
  logic ptr_last;
  logic in_dump;
  logic rs_byp, rt_byp, op_byp, dump_byp;

  // The sweep owns the storage write port, so writes during CLEAR are dropped
  // entirely, including their forwarding onto the read ports.
  assign wr_acc   = we_i && (state_q != ST_CLEAR);
  assign ptr_last = (ptr_q == PTR_LAST);
  assign in_dump  = (state_q == ST_DUMP);

  // ---------------- FSM ----------------
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end else if (dump_req_i) begin
          state_d = ST_DUMP;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Pointer wraps to 0 after DEPTH-1, leaving it ready for the next pass.
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_last) state_d = ST_IDLE;
      end
      ST_DUMP: begin
        if (dump_ready_i) begin
          ptr_d = ptr_q + PTR_ONE;
          if (ptr_last) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // ---------------- Storage and valid count ----------------
  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      vld_q     <= '0;
      vld_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      data_q[ptr_q] <= '0;
      tag_q[ptr_q]  <= '0;
      vld_q[ptr_q]  <= 1'b0;
      if (vld_q[ptr_q]) vld_cnt_q <= vld_cnt_q - CNT_ONE;
    end else if (we_i) begin
      data_q[wd_addr_i] <= wd_data_i;
      tag_q[wd_addr_i]  <= wd_tag_i;
      vld_q[wd_addr_i]  <= 1'b1;
      // Rewriting an already valid entry does not change the population.
      if (!vld_q[wd_addr_i]) vld_cnt_q <= vld_cnt_q + CNT_ONE;
    end
  end

  // ---------------- Read ports ----------------
  assign rs_byp   = BYP && wr_acc && (rs_addr_i == wd_addr_i);
  assign rt_byp   = BYP && wr_acc && (rt_addr_i == wd_addr_i);
  assign op_byp   = BYP && wr_acc && (op_addr_i == wd_addr_i);
  assign dump_byp = BYP && wr_acc && (ptr_q == wd_addr_i);

  assign rs_data_o = rs_byp ? wd_data_i : data_q[rs_addr_i];
  assign rt_data_o = rt_byp ? wd_data_i : data_q[rt_addr_i];
  assign op_data_o = op_byp ? wd_data_i : data_q[op_addr_i];
  assign op_tag_o  = op_byp ? wd_tag_i  : tag_q[op_addr_i];
  assign op_vld_o  = op_byp ? 1'b1      : vld_q[op_addr_i];

  // ---------------- Dump stream ----------------
  // Dump shows the live entry, so a write to the pointed entry during a stall
  // is visible on dump_data_o immediately (with bypass enabled).
  assign dump_valid_o = in_dump;
  assign dump_last_o  = in_dump && ptr_last;
  assign dump_addr_o  = in_dump ? ptr_q : '0;
  assign dump_data_o  = !in_dump ? '0 : (dump_byp ? wd_data_i : data_q[ptr_q]);
  assign dump_tag_o   = !in_dump ? '0 : (dump_byp ? wd_tag_i  : tag_q[ptr_q]);

  assign busy_o    = (state_q != ST_IDLE);
  assign vld_cnt_o = vld_cnt_q;

endmodule

// File: tb/tb_layer_regfile_mp.sv
module tb_layer_regfile_mp;

  localparam int DW = 32;
  localparam int TW = 4;
  localparam int D  = 32;
  localparam int AW = 5;

  logic          clk_i = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] rs_addr_i = '0, rt_addr_i = '0, op_addr_i = '0;
  logic          we_i = 1'b0;
  logic [AW-1:0] wd_addr_i = '0;
  logic [DW-1:0] wd_data_i = '0;
  logic [TW-1:0] wd_tag_i = '0;
  logic          clr_i = 1'b0, dump_req_i = 1'b0, dump_ready_i = 1'b0;

  logic [DW-1:0] rs_data_o, rt_data_o, op_data_o, dump_data_o;
  logic [TW-1:0] op_tag_o, dump_tag_o;
  logic          op_vld_o, dump_valid_o, dump_last_o, busy_o;
  logic [AW-1:0] dump_addr_o;
  logic [AW:0]   vld_cnt_o;

  logic [DW-1:0] nb_rs_data, nb_rt_data, nb_op_data, nb_dump_data;
  logic [TW-1:0] nb_op_tag, nb_dump_tag;
  logic          nb_op_vld, nb_dump_valid, nb_dump_last, nb_busy;
  logic [AW-1:0] nb_dump_addr;
  logic [AW:0]   nb_vld_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain arrays, population recounted from scratch.
  logic [DW-1:0] m_data [D];
  logic [TW-1:0] m_tag  [D];
  logic          m_vld  [D];

  always #5 clk_i = ~clk_i;

  layer_regfile_mp #(.DATA_W(DW), .TAG_W(TW), .DEPTH(D), .BYPASS(1)) dut (
    .clk_i(clk_i), .reset(reset),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .op_addr_i(op_addr_i),
    .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .op_data_o(op_data_o),
    .op_tag_o(op_tag_o), .op_vld_o(op_vld_o),
    .we_i(we_i), .wd_addr_i(wd_addr_i), .wd_data_i(wd_data_i), .wd_tag_i(wd_tag_i),
    .clr_i(clr_i), .dump_req_i(dump_req_i),
    .dump_valid_o(dump_valid_o), .dump_ready_i(dump_ready_i), .dump_addr_o(dump_addr_o),
    .dump_data_o(dump_data_o), .dump_tag_o(dump_tag_o), .dump_last_o(dump_last_o),
    .busy_o(busy_o), .vld_cnt_o(vld_cnt_o)
  );

  layer_regfile_mp #(.DATA_W(DW), .TAG_W(TW), .DEPTH(D), .BYPASS(0)) dut_nb (
    .clk_i(clk_i), .reset(reset),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .op_addr_i(op_addr_i),
    .rs_data_o(nb_rs_data), .rt_data_o(nb_rt_data), .op_data_o(nb_op_data),
    .op_tag_o(nb_op_tag), .op_vld_o(nb_op_vld),
    .we_i(we_i), .wd_addr_i(wd_addr_i), .wd_data_i(wd_data_i), .wd_tag_i(wd_tag_i),
    .clr_i(clr_i), .dump_req_i(dump_req_i),
    .dump_valid_o(nb_dump_valid), .dump_ready_i(dump_ready_i), .dump_addr_o(nb_dump_addr),
    .dump_data_o(nb_dump_data), .dump_tag_o(nb_dump_tag), .dump_last_o(nb_dump_last),
    .busy_o(nb_busy), .vld_cnt_o(nb_vld_cnt)
  );

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < D; i++) if (m_vld[i]) c++;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_data[i] = '0; m_tag[i] = '0; m_vld[i] = 1'b0;
    end
  endtask

  // Expected {data, tag, valid} at a read address given the current write inputs.
  function automatic logic [DW+TW:0] exp_rd(input logic [AW-1:0] a, input bit byp, input bit acc);
    if (byp && acc && we_i && a == wd_addr_i) return {wd_data_i, wd_tag_i, 1'b1};
    return {m_data[a], m_tag[a], m_vld[a]};
  endfunction

  task automatic model_write_if_we();
    if (we_i) begin
      m_data[wd_addr_i] = wd_data_i; m_tag[wd_addr_i] = wd_tag_i; m_vld[wd_addr_i] = 1'b1;
    end
  endtask

  task automatic idle_inputs();
    we_i = 1'b0; clr_i = 1'b0; dump_req_i = 1'b0; dump_ready_i = 1'b0;
  endtask

  // Cycle structure used everywhere: inputs set at posedge+1, checks at negedge,
  // model updated at the following posedge.
  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    n_checks++; if (dump_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_dump_valid got=%b exp=0", dump_valid_o); end
    n_checks++; if (vld_cnt_o !== 6'd0) begin n_fail++; $display("FAIL reset_vld_cnt got=%0d exp=0", vld_cnt_o); end
    op_addr_i = 5'd17; #1;
    n_checks++; if ({op_data_o, op_tag_o, op_vld_o} !== '0) begin n_fail++; $display("FAIL reset_entry got=%h exp=0", {op_data_o, op_tag_o, op_vld_o}); end
  endtask

  // Reset is released together with the write, so it lands on the first edge.
  task automatic test_first_write();
    @(negedge clk_i);
    reset = 1'b1;
    we_i = 1'b1; wd_addr_i = 5'd5; wd_data_i = 32'hDEADBEEF; wd_tag_i = 4'h3;
    @(posedge clk_i); model_write_if_we(); #1;
    we_i = 1'b0; op_addr_i = 5'd5;
    @(negedge clk_i);
    n_checks++; if (op_data_o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr5_data got=%h exp=deadbeef", op_data_o); end
    n_checks++; if (op_tag_o !== 4'h3) begin n_fail++; $display("FAIL wr5_tag got=%h exp=3", op_tag_o); end
    n_checks++; if (op_vld_o !== 1'b1) begin n_fail++; $display("FAIL wr5_vld got=%b exp=1", op_vld_o); end
    n_checks++; if (vld_cnt_o !== 6'd1) begin n_fail++; $display("FAIL wr5_cnt got=%0d exp=1", vld_cnt_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_bypass();
    we_i = 1'b1; wd_addr_i = 5'd7; wd_data_i = 32'h1234; wd_tag_i = 4'h9;
    rs_addr_i = 5'd7; op_addr_i = 5'd7;
    @(negedge clk_i);
    n_checks++; if (rs_data_o !== 32'h1234) begin n_fail++; $display("FAIL byp_rs got=%h exp=1234", rs_data_o); end
    n_checks++; if ({op_tag_o, op_vld_o} !== {4'h9, 1'b1}) begin n_fail++; $display("FAIL byp_op_tag_vld got=%h exp=%h", {op_tag_o, op_vld_o}, {4'h9, 1'b1}); end
    n_checks++; if (nb_rs_data !== 32'h0) begin n_fail++; $display("FAIL nobyp_rs got=%h exp=0", nb_rs_data); end
    n_checks++; if (nb_op_vld !== 1'b0) begin n_fail++; $display("FAIL nobyp_op_vld got=%b exp=0", nb_op_vld); end
    @(posedge clk_i); model_write_if_we(); #1;
    we_i = 1'b0;
    @(negedge clk_i);
    n_checks++; if (nb_rs_data !== 32'h1234) begin n_fail++; $display("FAIL nobyp_after got=%h exp=1234", nb_rs_data); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_random_rw();
    logic [DW+TW:0] e;
    for (int it = 0; it < 300; it++) begin
      we_i = ($urandom_range(0, 2) != 0);
      wd_addr_i = AW'($urandom); wd_data_i = $urandom; wd_tag_i = TW'($urandom);
      rs_addr_i = ($urandom_range(0, 3) == 0) ? wd_addr_i : AW'($urandom);
      rt_addr_i = ($urandom_range(0, 3) == 0) ? wd_addr_i : AW'($urandom);
      op_addr_i = ($urandom_range(0, 2) == 0) ? wd_addr_i : AW'($urandom);
      @(negedge clk_i);
      e = exp_rd(rs_addr_i, 1'b1, 1'b1);
      n_checks++; if (rs_data_o !== e[DW+TW:TW+1]) begin n_fail++; $display("FAIL rw_rs it=%0d got=%h exp=%h", it, rs_data_o, e[DW+TW:TW+1]); end
      e = exp_rd(rt_addr_i, 1'b1, 1'b1);
      n_checks++; if (rt_data_o !== e[DW+TW:TW+1]) begin n_fail++; $display("FAIL rw_rt it=%0d got=%h exp=%h", it, rt_data_o, e[DW+TW:TW+1]); end
      e = exp_rd(op_addr_i, 1'b1, 1'b1);
      n_checks++; if ({op_data_o, op_tag_o, op_vld_o} !== e) begin n_fail++; $display("FAIL rw_op it=%0d got=%h exp=%h", it, {op_data_o, op_tag_o, op_vld_o}, e); end
      e = exp_rd(rs_addr_i, 1'b0, 1'b1);
      n_checks++; if (nb_rs_data !== e[DW+TW:TW+1]) begin n_fail++; $display("FAIL rw_nb_rs it=%0d got=%h exp=%h", it, nb_rs_data, e[DW+TW:TW+1]); end
      n_checks++; if (int'(vld_cnt_o) != m_count()) begin n_fail++; $display("FAIL rw_cnt it=%0d got=%0d exp=%0d", it, vld_cnt_o, m_count()); end
      @(posedge clk_i); model_write_if_we(); #1;
    end
    we_i = 1'b0;
  endtask

  task automatic test_clear();
    logic [DW+TW:0] e;
    for (int k = 1; k <= 3; k++) begin
      we_i = 1'b1; wd_addr_i = AW'(k); wd_data_i = $urandom; wd_tag_i = TW'($urandom);
      @(posedge clk_i); model_write_if_we(); #1;
    end
    we_i = 1'b0; clr_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0;
    for (int k = 0; k < D; k++) begin
      // Writes aimed at the read port must be dropped and not forwarded.
      we_i = 1'b1; wd_addr_i = AW'($urandom); wd_data_i = $urandom | 32'h1; wd_tag_i = TW'($urandom);
      rs_addr_i = wd_addr_i;
      dump_req_i = (k == 5); clr_i = (k == 9);
      @(negedge clk_i);
      n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL clr_busy k=%0d got=%b exp=1", k, busy_o); end
      e = exp_rd(rs_addr_i, 1'b1, 1'b0);
      n_checks++; if (rs_data_o !== e[DW+TW:TW+1]) begin n_fail++; $display("FAIL clr_nobyp k=%0d got=%h exp=%h", k, rs_data_o, e[DW+TW:TW+1]); end
      n_checks++; if (int'(vld_cnt_o) != m_count()) begin n_fail++; $display("FAIL clr_cnt k=%0d got=%0d exp=%0d", k, vld_cnt_o, m_count()); end
      @(posedge clk_i);
      m_data[k] = '0; m_tag[k] = '0; m_vld[k] = 1'b0;
      #1;
    end
    idle_inputs();
    @(negedge clk_i);
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL clr_done_busy got=%b exp=0", busy_o); end
    n_checks++; if (dump_valid_o !== 1'b0) begin n_fail++; $display("FAIL clr_done_dump got=%b exp=0", dump_valid_o); end
    n_checks++; if (vld_cnt_o !== 6'd0) begin n_fail++; $display("FAIL clr_done_cnt got=%0d exp=0", vld_cnt_o); end
    @(posedge clk_i); #1;
    for (int a = 0; a < D; a++) begin
      op_addr_i = AW'(a);
      @(negedge clk_i);
      n_checks++; if ({op_data_o, op_tag_o, op_vld_o} !== '0) begin n_fail++; $display("FAIL clr_entry a=%0d got=%h exp=0", a, {op_data_o, op_tag_o, op_vld_o}); end
      @(posedge clk_i); #1;
    end
  endtask

  task automatic test_dump();
    logic [DW+TW:0] e;
    int idx, cyc;
    for (int k = 0; k < 40; k++) begin
      we_i = 1'b1; wd_addr_i = AW'($urandom); wd_data_i = $urandom; wd_tag_i = TW'($urandom);
      @(posedge clk_i); model_write_if_we(); #1;
    end
    we_i = 1'b0; dump_req_i = 1'b1;
    @(posedge clk_i); #1;
    dump_req_i = 1'b0;
    idx = 0; cyc = 0;
    while (idx < D && cyc < 200) begin
      dump_ready_i = (cyc % 2 == 0);
      we_i = ($urandom_range(0, 2) == 0);
      wd_addr_i = ($urandom_range(0, 1) == 0) ? AW'(idx) : AW'($urandom);
      wd_data_i = $urandom; wd_tag_i = TW'($urandom);
      clr_i = (cyc == 7);
      @(negedge clk_i);
      e = exp_rd(AW'(idx), 1'b1, 1'b1);
      n_checks++; if (dump_valid_o !== 1'b1) begin n_fail++; $display("FAIL dump_valid idx=%0d got=%b exp=1", idx, dump_valid_o); end
      n_checks++; if (int'(dump_addr_o) != idx) begin n_fail++; $display("FAIL dump_addr got=%0d exp=%0d", dump_addr_o, idx); end
      n_checks++; if ({dump_data_o, dump_tag_o} !== e[DW+TW:1]) begin n_fail++; $display("FAIL dump_data idx=%0d got=%h exp=%h", idx, {dump_data_o, dump_tag_o}, e[DW+TW:1]); end
      n_checks++; if (dump_last_o !== (idx == D - 1)) begin n_fail++; $display("FAIL dump_last idx=%0d got=%b exp=%b", idx, dump_last_o, idx == D - 1); end
      @(posedge clk_i); model_write_if_we();
      if (dump_ready_i) idx++;
      #1; cyc++;
    end
    n_checks++; if (idx != D) begin n_fail++; $display("FAIL dump_count got=%0d exp=%0d (cycle budget)", idx, D); end
    idle_inputs();
    @(negedge clk_i);
    n_checks++; if ({busy_o, dump_valid_o, dump_last_o} !== 3'b000) begin n_fail++; $display("FAIL dump_end_state got=%b exp=000", {busy_o, dump_valid_o, dump_last_o}); end
    n_checks++; if ({dump_addr_o, dump_data_o, dump_tag_o} !== '0) begin n_fail++; $display("FAIL dump_end_zero got=%h exp=0", {dump_addr_o, dump_data_o, dump_tag_o}); end
    n_checks++; if (int'(vld_cnt_o) != m_count()) begin n_fail++; $display("FAIL dump_end_cnt got=%0d exp=%0d", vld_cnt_o, m_count()); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_clr_dump_same();
    clr_i = 1'b1; dump_req_i = 1'b1; dump_ready_i = 1'b1;
    @(posedge clk_i); #1;
    clr_i = 1'b0; dump_req_i = 1'b0;
    for (int k = 0; k < D; k++) begin
      @(negedge clk_i);
      n_checks++; if ({busy_o, dump_valid_o} !== 2'b10) begin n_fail++; $display("FAIL both_sweep k=%0d got=%b exp=10", k, {busy_o, dump_valid_o}); end
      @(posedge clk_i);
      m_data[k] = '0; m_tag[k] = '0; m_vld[k] = 1'b0;
      #1;
    end
    idle_inputs();
    @(negedge clk_i);
    n_checks++; if ({busy_o, dump_valid_o} !== 2'b00) begin n_fail++; $display("FAIL both_done got=%b exp=00", {busy_o, dump_valid_o}); end
    n_checks++; if (vld_cnt_o !== 6'd0) begin n_fail++; $display("FAIL both_cnt got=%0d exp=0", vld_cnt_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset_mid_dump();
    int cyc;
    for (int k = 0; k < 12; k++) begin
      we_i = 1'b1; wd_addr_i = AW'(k * 2); wd_data_i = $urandom | 32'h1; wd_tag_i = TW'($urandom);
      @(posedge clk_i); model_write_if_we(); #1;
    end
    we_i = 1'b0; dump_req_i = 1'b1;
    @(posedge clk_i); #1;
    dump_req_i = 1'b0; dump_ready_i = 1'b1;
    cyc = 0;
    @(negedge clk_i);
    while (dump_addr_o != 5'd10 && cyc < 40) begin
      @(negedge clk_i); cyc++;
    end
    n_checks++; if (dump_addr_o !== 5'd10 || dump_valid_o !== 1'b1) begin n_fail++; $display("FAIL rst_dump_reach got=%0d/%b exp=10/1", dump_addr_o, dump_valid_o); end
    reset = 1'b0;
    model_reset();
    op_addr_i = 5'd4;
    #1;
    n_checks++; if ({dump_valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL rst_dump_now got=%b exp=00", {dump_valid_o, busy_o}); end
    n_checks++; if (vld_cnt_o !== 6'd0) begin n_fail++; $display("FAIL rst_dump_cnt got=%0d exp=0", vld_cnt_o); end
    n_checks++; if ({op_data_o, op_tag_o, op_vld_o} !== '0) begin n_fail++; $display("FAIL rst_dump_entry got=%h exp=0", {op_data_o, op_tag_o, op_vld_o}); end
    @(negedge clk_i);
    reset = 1'b1; dump_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk_i); #1;
      @(negedge clk_i);
      n_checks++; if ({busy_o, dump_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rst_no_resume k=%0d got=%b exp=00", k, {busy_o, dump_valid_o}); end
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_write();
    test_bypass();
    test_random_rw();
    test_clear();
    test_dump();
    test_clr_dump_same();
    test_random_rw();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
